// File: rtl/mem_arbiter.sv
// mem_arbiter: single owner of the byte-wide RAM port, shared by instruction
// fetch and MEM-stage loads/stores. Accesses of 1/2/4 bytes are serialised
// into byte cycles and assembled little-endian. MEM wins over IF.
module mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              flush,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_inst,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_len,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_done,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              stall_mem,
   input  logic [7:0]        ram_din,
   output logic [7:0]        ram_dout,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   typedef enum logic {OWN_IF, OWN_MEM} owner_t;

   state_t            state_q;
   owner_t            owner_q;
   logic              we_q;
   logic [2:0]        n_q;
   logic [2:0]        cnt_q;
   logic [2:0]        cnt_nxt;
   logic [2:0]        req_n;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] buf_q;
   logic [DATA_W-1:0] if_inst_q;
   logic [DATA_W-1:0] mem_rdata_q;
   logic [ADDR_W-1:0] ram_a_q;
   logic [7:0]        ram_dout_q;
   logic              ram_wr_q;
   logic              if_done_q;
   logic              mem_done_q;

   assign cnt_nxt = cnt_q + 3'd1;

   // Byte count of a MEM request; length code 11 behaves as a word.
   always_comb begin
      case (mem_len)
         2'b00:   req_n = 3'd1;
         2'b01:   req_n = 3'd2;
         default: req_n = 3'd4;
      endcase
   end

   // Access sequencer: accept, issue/sample bytes, pulse done, return to IDLE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         we_q        <= 1'b0;
         n_q         <= '0;
         cnt_q       <= '0;
         wdata_q     <= '0;
         buf_q       <= '0;
         if_inst_q   <= '0;
         mem_rdata_q <= '0;
         ram_a_q     <= '0;
         ram_dout_q  <= '0;
         ram_wr_q    <= 1'b0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
      end else if (rdy) begin
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               buf_q <= '0;
               if (mem_req) begin
                  owner_q <= OWN_MEM;
                  we_q    <= mem_we;
                  wdata_q <= mem_wdata;
                  n_q     <= req_n;
                  ram_a_q <= mem_addr;
                  if (mem_we) begin
                     ram_dout_q <= mem_wdata[7:0];
                     ram_wr_q   <= 1'b1;
                     state_q    <= WRITE;
                  end else begin
                     state_q <= READ;
                  end
               end else if (if_req && !flush) begin
                  owner_q <= OWN_IF;
                  we_q    <= 1'b0;
                  n_q     <= 3'd4;
                  ram_a_q <= if_addr;
                  state_q <= READ;
               end
            end
            READ: begin
               if (owner_q == OWN_IF && flush) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_nxt;
                  if (cnt_nxt < n_q)
                     ram_a_q <= ram_a_q + ADDR_W'(1);
                  // byte addressed in cycle k is on ram_din in cycle k+1
                  if (cnt_q != 3'd0)
                     buf_q <= buf_q | (DATA_W'(ram_din) << {cnt_q - 3'd1, 3'b000});
                  if (cnt_q == n_q) begin
                     state_q <= DONE;
                     if (owner_q == OWN_IF)
                        if_done_q <= 1'b1;
                     else
                        mem_done_q <= 1'b1;
                  end
               end
            end
            WRITE: begin
               cnt_q <= cnt_nxt;
               if (cnt_nxt < n_q) begin
                  ram_a_q    <= ram_a_q + ADDR_W'(1);
                  ram_dout_q <= 8'(wdata_q >> {cnt_nxt, 3'b000});
               end else begin
                  ram_wr_q   <= 1'b0;
                  mem_done_q <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
               // held data only commits once the done cycle is not flushed away
               if (owner_q == OWN_IF && !flush)
                  if_inst_q <= buf_q;
               if (owner_q == OWN_MEM && !we_q)
                  mem_rdata_q <= buf_q;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_done   = if_done_q & ~flush;
   assign if_inst   = if_done ? buf_q : if_inst_q;
   assign mem_done  = mem_done_q;
   assign mem_rdata = (mem_done_q && !we_q) ? buf_q : mem_rdata_q;
   assign stall_mem = mem_req & ~mem_done;
   assign ram_a     = ram_a_q;
   assign ram_dout  = ram_dout_q;
   assign ram_wr    = ram_wr_q & rdy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, hand-written corner sequences and random
// traffic checked against a byte-array memory model.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        flush;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_inst;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_len;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic        stall_mem;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr;

   int checks = 0;
   int errors = 0;

   logic [7:0] ram     [4096];
   logic [7:0] ref_mem [4096];

   typedef struct {
      bit          is_if;
      bit          we;
      logic [1:0]  len;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] data;
   } vec_t;

   vec_t        tbl [9];
   logic [31:0] wrap_exp [7];
   int          lat, mlat, ilat;
   logic [31:0] got, mdat, idat, hold;
   bit          flag;
   bit          r_if, r_we;
   logic [1:0]  r_len;
   logic [31:0] r_addr, r_wd, r_exp;
   int          r_n;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .stall_mem(stall_mem), .ram_din(ram_din), .ram_dout(ram_dout),
      .ram_a(ram_a), .ram_wr(ram_wr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM: one-cycle read latency, frozen with the rest of the system by rdy;
   // while in reset it is reloaded from the model image.
   always @(posedge clk) begin
      if (rdy) ram_din <= ram[ram_a[11:0]];
      if (!rst) begin
         for (int i = 0; i < 4096; i++) ram[i] <= ref_mem[i];
      end else if (ram_wr) begin
         ram[ram_a[11:0]] <= ram_dout;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   function automatic int model_n(bit is_if, logic [1:0] len);
      if (is_if) return 4;
      return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
   endfunction

   function automatic int model_lat(bit is_if, bit we, logic [1:0] len);
      return (!is_if && we) ? model_n(is_if, len) + 1 : model_n(is_if, len) + 2;
   endfunction

   function automatic logic [31:0] model_load(logic [31:0] addr, int n);
      logic [31:0] v = '0;
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         a = addr + 32'(i);
         v = v | (32'(ref_mem[a[11:0]]) << (8 * i));
      end
      return v;
   endfunction

   task automatic model_store(input logic [31:0] addr, input logic [31:0] wd, input int n);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         a = addr + 32'(i);
         ref_mem[a[11:0]] = 8'(wd >> (8 * i));
      end
   endtask

   // One access from the IDLE cycle (called at posedge+1 of cycle 0).
   task automatic run_txn(input bit is_if, input bit we, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_data,
                          input bit rand_flush, input string tag);
      int          n = model_n(is_if, len);
      bit          st = !is_if && we;
      bit          trace_ok = 1'b1;
      bit          stall_ok = 1'b1;
      int          olat = -1;
      int          wr_cnt = 0;
      logic [31:0] odata = '0;
      if (is_if) begin
         if_req = 1'b1; if_addr = addr;
      end else begin
         mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
      end
      for (int c = 0; c <= 15; c++) begin
         if (rand_flush) flush = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (ram_wr) wr_cnt++;
         if (c >= 1 && c <= n) begin
            if (ram_a !== addr + 32'(c - 1)) trace_ok = 1'b0;
            if (st && ram_dout !== 8'(wdata >> (8 * (c - 1)))) trace_ok = 1'b0;
         end
         if (is_if ? mem_done : if_done) trace_ok = 1'b0;
         if (is_if ? if_done : mem_done) begin
            olat = c;
            odata = is_if ? if_inst : mem_rdata;
            if (!is_if && stall_mem !== 1'b0) stall_ok = 1'b0;
            break;
         end
         if (!is_if && stall_mem !== 1'b1) stall_ok = 1'b0;
         @(posedge clk); #1;
      end
      flush = 1'b0;
      @(posedge clk); #1;
      if (is_if) if_req = 1'b0; else mem_req = 1'b0;
      if ((is_if ? if_done : mem_done) !== 1'b0) trace_ok = 1'b0;
      chk({tag, "_latency"}, 32'(olat), 32'(exp_lat));
      if (!st) chk({tag, "_data"}, odata, exp_data);
      chk({tag, "_wr_count"}, 32'(wr_cnt), st ? 32'(n) : 32'd0);
      chk({tag, "_trace"}, {31'd0, trace_ok}, 32'd1);
      if (!is_if) chk({tag, "_stall_mem"}, {31'd0, stall_ok}, 32'd1);
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1; flush = 1'b0;
      if_req = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_we = 1'b0; mem_len = '0; mem_addr = '0; mem_wdata = '0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
      ref_mem[12'h100] = 8'h13; ref_mem[12'h101] = 8'h05;
      ref_mem[12'h102] = 8'h00; ref_mem[12'h103] = 8'h00;
      ref_mem[12'h104] = 8'h93; ref_mem[12'h105] = 8'h05;
      ref_mem[12'h106] = 8'h10; ref_mem[12'h107] = 8'h00;
      ref_mem[12'h300] = 8'h80;
      ref_mem[12'hFFE] = 8'h11; ref_mem[12'hFFF] = 8'h22;
      ref_mem[12'h000] = 8'h33; ref_mem[12'h001] = 8'h44;

      tbl[0] = '{1'b1, 1'b0, 2'd2, 32'h100, 32'h0,        6, 32'h00000513};
      tbl[1] = '{1'b0, 1'b1, 2'd1, 32'h200, 32'hAABBCCDD, 3, 32'h0};
      tbl[2] = '{1'b0, 1'b0, 2'd1, 32'h200, 32'h0,        4, 32'h0000CCDD};
      tbl[3] = '{1'b0, 1'b0, 2'd0, 32'h201, 32'h0,        3, 32'h000000CC};
      tbl[4] = '{1'b0, 1'b0, 2'd3, 32'h100, 32'h0,        6, 32'h00000513};
      tbl[5] = '{1'b0, 1'b1, 2'd0, 32'h210, 32'h12345678, 2, 32'h0};
      tbl[6] = '{1'b0, 1'b0, 2'd2, 32'h210, 32'h0,        6, 32'h00000078};
      tbl[7] = '{1'b0, 1'b1, 2'd2, 32'h220, 32'hDEADBEEF, 5, 32'h0};
      tbl[8] = '{1'b1, 1'b0, 2'd2, 32'h220, 32'h0,        6, 32'hDEADBEEF};
      wrap_exp = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFF, 32'h00000000, 32'h00000001};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_if_done", {31'd0, if_done}, 32'd0);
      chk("rst_mem_done", {31'd0, mem_done}, 32'd0);
      chk("rst_if_inst", if_inst, 32'd0);
      chk("rst_mem_rdata", mem_rdata, 32'd0);
      chk("rst_ram_a", ram_a, 32'd0);
      chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
      chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // table vectors
      for (int v = 0; v < 9; v++) begin
         run_txn(tbl[v].is_if, tbl[v].we, tbl[v].len, tbl[v].addr, tbl[v].wdata,
                 tbl[v].lat, tbl[v].data, 1'b0, $sformatf("vec%0d", v));
         if (!tbl[v].is_if && tbl[v].we)
            model_store(tbl[v].addr, tbl[v].wdata, model_n(1'b0, tbl[v].len));
      end

      // contention: MEM byte load wins, IF follows after DONE
      if_req = 1'b1; if_addr = 32'h100;
      mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h300;
      mlat = -1; ilat = -1; mdat = '0; idat = '0; hold = '0;
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         if (mem_done && mlat < 0) begin mlat = c; mdat = mem_rdata; end
         if (if_done && ilat < 0) begin ilat = c; idat = if_inst; hold = mem_rdata; end
         if (ilat >= 0) break;
         @(posedge clk); #1;
         if (mlat >= 0) mem_req = 1'b0;
      end
      @(posedge clk); #1;
      if_req = 1'b0;
      chk("cont_mem_latency", 32'(mlat), 32'd3);
      chk("cont_mem_rdata", mdat, 32'h00000080);
      chk("cont_if_latency", 32'(ilat), 32'd10);
      chk("cont_if_inst", idat, 32'h00000513);
      chk("cont_mem_rdata_hold", hold, 32'h00000080);

      // flush during fetch, then a clean refetch
      if_req = 1'b1; if_addr = 32'h100; flag = 1'b1;
      for (int c = 0; c <= 3; c++) begin
         @(negedge clk);
         if (if_done || ram_wr) flag = 1'b0;
         @(posedge clk); #1;
         if (c == 2) flush = 1'b1;
      end
      flush = 1'b0;
      chk("flush_no_done", {31'd0, flag}, 32'd1);
      run_txn(1'b1, 1'b0, 2'd2, 32'h104, 32'h0, 6, 32'h00100593, 1'b0, "flush_refetch");

      // flush in the done cycle suppresses the pulse and keeps old data
      if_req = 1'b1; if_addr = 32'h100;
      repeat (6) begin @(posedge clk); #1; end
      flush = 1'b1;
      #1;
      chk("flush_done_pulse", {31'd0, if_done}, 32'd0);
      chk("flush_done_inst", if_inst, 32'h00100593);
      @(posedge clk); #1;
      flush = 1'b0; if_req = 1'b0;
      #1;
      chk("flush_done_hold", if_inst, 32'h00100593);

      // rdy freeze mid-access plus address wrap
      mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b10; mem_addr = 32'hFFFFFFFE;
      lat = -1; got = '0; flag = 1'b0;
      for (int c = 0; c <= 20; c++) begin
         rdy = !(c >= 2 && c <= 4);
         @(negedge clk);
         if (ram_wr) flag = 1'b1;
         if (c >= 1 && c <= 7) chk($sformatf("wrap_ram_a_c%0d", c), ram_a, wrap_exp[c-1]);
         if (mem_done) begin lat = c; got = mem_rdata; break; end
         @(posedge clk); #1;
      end
      rdy = 1'b1;
      @(posedge clk); #1;
      mem_req = 1'b0;
      chk("wrap_latency", 32'(lat), 32'd9);
      chk("wrap_data", got, 32'h44332211);
      chk("wrap_no_wr", {31'd0, flag}, 32'd0);

      // reset during the second write cycle
      mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h400; mem_wdata = 32'hCAFEF00D;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1; mem_req = 1'b0;
      chk("midrst_ram_a", ram_a, 32'd0);
      chk("midrst_ram_dout", {24'd0, ram_dout}, 32'd0);
      chk("midrst_ram_wr", {31'd0, ram_wr}, 32'd0);
      chk("midrst_mem_rdata", mem_rdata, 32'd0);
      chk("midrst_if_inst", if_inst, 32'd0);
      flag = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (mem_done || if_done || ram_wr) flag = 1'b1;
      end
      @(posedge clk); #1;
      chk("midrst_no_done", {31'd0, flag}, 32'd0);

      // random traffic against the memory model
      for (int t = 0; t < 40; t++) begin
         r_if   = ($urandom_range(0, 2) == 0);
         r_we   = r_if ? 1'b0 : 1'($urandom_range(0, 1));
         r_len  = 2'($urandom_range(0, 3));
         r_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                              : 32'h500 + 32'($urandom_range(0, 255));
         r_wd   = $urandom;
         r_n    = model_n(r_if, r_len);
         r_exp  = (r_if || !r_we) ? model_load(r_addr, r_n) : 32'h0;
         run_txn(r_if, r_we, r_len, r_addr, r_wd, model_lat(r_if, r_we, r_len), r_exp,
                 !r_if, $sformatf("rnd%0d", t));
         if (!r_if && r_we) model_store(r_addr, r_wd, r_n);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
